// File: rtl/fifo_pkg.sv
// Shared constants and gray-code helpers for the TX PCS asynchronous FIFO.
// Reused by the write-side and read-side controllers.
package fifo_pkg;

    localparam int ADDRSIZE = 7;
    localparam int DSIZE    = 66;
    // Helpers work on zero-extended pointers of any width up to GRAY_W bits.
    localparam int GRAY_W   = 32;

    function automatic logic [GRAY_W-1:0] bin2gray(input logic [GRAY_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic logic [GRAY_W-1:0] gray2bin(input logic [GRAY_W-1:0] gray);
        logic [GRAY_W-1:0] bin;
        bin[GRAY_W-1] = gray[GRAY_W-1];
        for (int i = GRAY_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/fifo_rd_ctrl_if.sv
// Valid/ready word stream leaving the read side of the TX PCS FIFO.
interface fifo_rd_ctrl_if #(
    parameter int DSIZE = fifo_pkg::DSIZE
);
    logic             out_valid;
    logic             out_ready;
    logic [DSIZE-1:0] out_data;

    modport master (output out_valid, output out_data, input  out_ready);
    modport slave  (input  out_valid, input  out_data, output out_ready);
endinterface

// File: rtl/fifo_out_buf.sv
// Two-entry output buffer: head register drives the consumer, tail absorbs
// the word that arrives while the head is stalled.
module fifo_out_buf #(
    parameter int DSIZE = 66
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [DSIZE-1:0] din,
    output logic [1:0]       occ,
    output logic             valid,
    output logic [DSIZE-1:0] head
);

    logic [DSIZE-1:0] head_r;
    logic [DSIZE-1:0] tail_r;
    logic [1:0]       occ_r;

    // Head/tail storage and occupancy; a simultaneous push and pop keeps occupancy.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            head_r <= {DSIZE{1'b0}};
            tail_r <= {DSIZE{1'b0}};
            occ_r  <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ_r == 2'd0) begin
                        head_r <= din;
                        occ_r  <= 2'd1;
                    end else if (occ_r == 2'd1) begin
                        tail_r <= din;
                        occ_r  <= 2'd2;
                    end else begin
                        occ_r  <= occ_r;
                    end
                end
                2'b01: begin
                    if (occ_r == 2'd2) begin
                        head_r <= tail_r;
                    end else begin
                        head_r <= head_r;
                    end
                    occ_r <= occ_r - 2'd1;
                end
                2'b11: begin
                    if (occ_r == 2'd2) begin
                        head_r <= tail_r;
                        tail_r <= din;
                    end else begin
                        head_r <= din;
                    end
                end
                default: begin
                    occ_r <= occ_r;
                end
            endcase
        end
    end

    assign occ   = occ_r;
    assign valid = (occ_r != 2'd0);
    assign head  = head_r;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the TX PCS asynchronous FIFO: read pointer, empty,
// level and almost-empty flags, and RAM fetch sequencing into the output buffer.
module fifo_rd_ctrl #(
    parameter int ADDRSIZE  = 7,
    parameter int DSIZE     = 66,
    parameter int AE_THRESH = 4
) (
    input  logic                rclk,
    input  logic                rrst_n,
    input  logic [ADDRSIZE:0]   rq2_wptr,
    output logic [ADDRSIZE:0]   rptr,
    output logic [ADDRSIZE-1:0] raddr,
    output logic                rd_en,
    input  logic [DSIZE-1:0]    rdata,
    output logic                rempty,
    output logic [ADDRSIZE:0]   rlevel,
    output logic                ralmost_empty,
    fifo_rd_ctrl_if.master      out_if
);

    import fifo_pkg::*;

    localparam int PW = ADDRSIZE + 1;

    logic [PW-1:0]     rbin_r;
    logic [PW-1:0]     rptr_r;
    logic [PW-1:0]     rlevel_r;
    logic              rempty_r;
    logic              ralmost_empty_r;
    logic              inflight_r;

    logic [PW-1:0]     rbin_next_s;
    logic [PW-1:0]     rgray_next_s;
    logic [PW-1:0]     wbin_s;
    logic [PW-1:0]     level_next_s;
    logic [GRAY_W-1:0] gray_wide_s;
    logic [GRAY_W-1:0] wbin_wide_s;
    logic              unused_hi_s;

    logic [1:0]        occ_s;
    logic              buf_valid_s;
    logic [DSIZE-1:0]  buf_head_s;
    logic              pop_s;
    logic              rd_en_s;
    logic [2:0]        pending_s;

    // Next read pointer in binary and gray, and the synchronized write pointer in binary.
    always_comb begin
        rbin_next_s  = rbin_r + {{(PW-1){1'b0}}, rd_en_s};
        gray_wide_s  = bin2gray(GRAY_W'(rbin_next_s));
        rgray_next_s = gray_wide_s[PW-1:0];
        wbin_wide_s  = gray2bin(GRAY_W'(rq2_wptr));
        wbin_s       = wbin_wide_s[PW-1:0];
        level_next_s = wbin_s - rbin_next_s;
    end

    assign unused_hi_s = ^{gray_wide_s[GRAY_W-1:PW], wbin_wide_s[GRAY_W-1:PW]};

    assign pop_s = buf_valid_s & out_if.out_ready;

    // Fetch only while buffered plus in-flight words, after this cycle's pop, leave a free slot.
    always_comb begin
        pending_s = {1'b0, occ_s} + {2'b00, inflight_r} - {2'b00, pop_s};
        if (rempty_r) begin
            rd_en_s = 1'b0;
        end else begin
            rd_en_s = (pending_s < 3'd2);
        end
    end

    // Read pointer, empty/level flags and the in-flight marker for the RAM's one-cycle latency.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin_r          <= {PW{1'b0}};
            rptr_r          <= {PW{1'b0}};
            rempty_r        <= 1'b1;
            rlevel_r        <= {PW{1'b0}};
            ralmost_empty_r <= 1'b1;
            inflight_r      <= 1'b0;
        end else begin
            rbin_r          <= rbin_next_s;
            rptr_r          <= rgray_next_s;
            rempty_r        <= (rgray_next_s == rq2_wptr);
            rlevel_r        <= level_next_s;
            ralmost_empty_r <= (level_next_s <= PW'(AE_THRESH));
            inflight_r      <= rd_en_s;
        end
    end

    fifo_out_buf #(
        .DSIZE (DSIZE)
    ) u_out_buf (
        .rclk   (rclk),
        .rrst_n (rrst_n),
        .push   (inflight_r),
        .pop    (pop_s),
        .din    (rdata),
        .occ    (occ_s),
        .valid  (buf_valid_s),
        .head   (buf_head_s)
    );

    assign rptr             = rptr_r;
    assign raddr            = rbin_r[ADDRSIZE-1:0];
    assign rd_en            = rd_en_s;
    assign rempty           = rempty_r;
    assign rlevel           = rlevel_r;
    assign ralmost_empty    = ralmost_empty_r;
    assign out_if.out_valid = buf_valid_s;
    assign out_if.out_data  = buf_head_s;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: acts as write side and RAM, checks every cycle against
// a count-based model (words written, fetched, delivered) plus literal pins.
module tb_fifo_rd_ctrl;

    localparam int AW    = 7;
    localparam int DW    = 66;
    localparam int PW    = AW + 1;
    localparam int DEPTH = 128;
    localparam int AE    = 4;

    logic          rclk   = 1'b0;
    logic          rrst_n = 1'b0;
    logic [PW-1:0] rq2_wptr = '0;
    logic [PW-1:0] rptr;
    logic [AW-1:0] raddr;
    logic          rd_en;
    logic [DW-1:0] rdata = '0;
    logic          rempty;
    logic [PW-1:0] rlevel;
    logic          ralmost_empty;

    fifo_rd_ctrl_if #(.DSIZE(DW)) out_if ();

    fifo_rd_ctrl #(
        .ADDRSIZE  (AW),
        .DSIZE     (DW),
        .AE_THRESH (AE)
    ) dut (
        .rclk          (rclk),
        .rrst_n        (rrst_n),
        .rq2_wptr      (rq2_wptr),
        .rptr          (rptr),
        .raddr         (raddr),
        .rd_en         (rd_en),
        .rdata         (rdata),
        .rempty        (rempty),
        .rlevel        (rlevel),
        .ralmost_empty (ralmost_empty),
        .out_if        (out_if)
    );

    always #5 rclk = ~rclk;

    // Synchronous-read RAM model, one cycle latency.
    logic [DW-1:0] ram [DEPTH];
    always @(posedge rclk) if (rd_en) rdata <= ram[raddr];

    int tests = 0;
    int fails = 0;
    int wcnt, rcnt, rcnt_d, pcnt;
    logic [DW-1:0] exp_q [$];

    function automatic logic [PW-1:0] gray(input int v);
        logic [PW-1:0] b;
        b = PW'(v);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        wcnt = 0; rcnt = 0; rcnt_d = 0; pcnt = 0;
        exp_q.delete();
    endtask

    // One cycle: check registered outputs at negedge, drive inputs, then check rd_en.
    task automatic step(input bit rdy, input int nwr);
        bit exp_valid, exp_rd, pop;
        int wsync, lvl;
        logic [DW-1:0] w;
        @(negedge rclk);
        wsync     = wcnt;
        lvl       = wcnt - rcnt;
        exp_valid = (rcnt_d - pcnt) > 0;
        chk("rempty", rempty, (lvl == 0));
        chk("rlevel", rlevel, lvl);
        chk("ralmost_empty", ralmost_empty, (lvl <= AE));
        chk("rptr", rptr, gray(rcnt));
        chk("raddr", raddr, rcnt % DEPTH);
        chk("out_valid", out_if.out_valid, exp_valid);
        if (exp_valid && exp_q.size() > 0) chk("out_data", out_if.out_data, exp_q[0]);
        out_if.out_ready = rdy;
        for (int i = 0; i < nwr; i++) begin
            if (wcnt - rcnt < DEPTH) begin
                w = {$urandom, $urandom, 2'($urandom)};
                ram[wcnt % DEPTH] = w;
                exp_q.push_back(w);
                wcnt++;
            end
        end
        rq2_wptr = gray(wcnt);
        #1;
        pop    = exp_valid && rdy;
        exp_rd = (rcnt != wsync) && ((rcnt - pcnt - int'(pop)) < 2);
        chk("rd_en", rd_en, exp_rd);
        if (pop && exp_q.size() > 0) void'(exp_q.pop_front());
        rcnt_d = rcnt;
        rcnt   = rcnt + int'(exp_rd);
        pcnt   = pcnt + int'(pop);
    endtask

    initial begin
        int pops, wraps, i;
        logic [PW-1:0] prev_rptr;
        out_if.out_ready = 1'b0;
        model_clear();
        repeat (3) @(negedge rclk);
        rrst_n = 1'b1;

        // Idle after reset: empty, never reads.
        repeat (5) step(1'b0, 0);
        chk("pin_idle_rempty", rempty, 1'b1);
        chk("pin_idle_ae", ralmost_empty, 1'b1);
        chk("pin_idle_rlevel", rlevel, 0);
        chk("pin_idle_valid", out_if.out_valid, 1'b0);
        chk("pin_idle_rptr", rptr, 0);

        // Single word: rempty falls, read at 0, out_valid two cycles later.
        step(1'b1, 1);
        step(1'b1, 0);
        chk("pin_single_rempty_low", rempty, 1'b0);
        chk("pin_single_rd_en", rd_en, 1'b1);
        chk("pin_single_raddr", raddr, 0);
        step(1'b1, 0);
        chk("pin_single_rempty_back", rempty, 1'b1);
        chk("pin_single_rptr", rptr, 8'h01);
        chk("pin_single_valid_early", out_if.out_valid, 1'b0);
        step(1'b1, 0);
        chk("pin_single_valid", out_if.out_valid, 1'b1);
        repeat (3) step(1'b1, 0);

        // Ten words with the consumer stalled: only two fetched.
        step(1'b0, 10);
        repeat (10) step(1'b0, 0);
        chk("pin_stall_rlevel", rlevel, 8);
        chk("pin_stall_valid", out_if.out_valid, 1'b1);
        chk("pin_stall_ae", ralmost_empty, 1'b0);
        pops = 0;
        repeat (14) begin
            step(1'b1, 0);
            if (out_if.out_valid && out_if.out_ready) pops++;
        end
        chk("pin_stall_pops", pops, 10);

        // Fill to capacity with the consumer stalled.
        repeat (6) step(1'b0, 40);
        step(1'b0, 0);
        chk("pin_full_rlevel", rlevel, 128);
        chk("pin_full_rptr", rptr, 8'h0B);
        chk("pin_full_rempty", rempty, 1'b0);

        // Random traffic across many pointer wraps.
        wraps = 0;
        prev_rptr = rptr;
        for (i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 3) != 0) && ((i % 200) > 30), $urandom_range(0, 2));
            if (prev_rptr == 8'h80 && rptr != 8'h80) begin
                chk("wrap_rptr", rptr, 8'h00);
                wraps++;
            end
            prev_rptr = rptr;
        end
        chk("pin_wrap_seen", (wraps > 0), 1'b1);

        // Drain, bounded.
        for (i = 0; i < 400 && pcnt != wcnt; i++) step(1'b1, 0);
        tests++;
        if (pcnt != wcnt) begin
            fails++;
            $display("FAIL drain_timeout: delivered %0d of %0d", pcnt, wcnt);
        end
        step(1'b1, 0);
        chk("pin_drain_rempty", rempty, 1'b1);
        chk("pin_drain_valid", out_if.out_valid, 1'b0);

        // Reset in the middle of a stream.
        step(1'b1, 20);
        repeat (5) step(1'b1, 0);
        chk("pin_prereset_valid", out_if.out_valid, 1'b1);
        @(negedge rclk);
        #2;
        rrst_n = 1'b0;
        #1;
        chk("rst_rempty", rempty, 1'b1);
        chk("rst_ae", ralmost_empty, 1'b1);
        chk("rst_rlevel", rlevel, 0);
        chk("rst_rptr", rptr, 0);
        chk("rst_raddr", raddr, 0);
        chk("rst_rd_en", rd_en, 1'b0);
        chk("rst_valid", out_if.out_valid, 1'b0);
        chk("rst_data", out_if.out_data, 0);
        model_clear();
        rq2_wptr = '0;
        out_if.out_ready = 1'b0;
        @(posedge rclk);
        #2;
        rrst_n = 1'b1;
        repeat (5) step(1'b1, 0);
        step(1'b1, 3);
        repeat (8) step(1'b1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
